// File: rtl/two_bit_comparator.sv
// Registered unsigned magnitude/equality comparator, one-cycle valid-qualified latency.
// Define STICKY_OR_EN to add the sticky/sticky_clr match accumulator.
module two_bit_comparator #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef STICKY_OR_EN
    input  logic             sticky_clr,
    output logic             sticky,
`endif
    output logic             out_valid,
    output logic             y,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic vld_q, vld_d;
    logic eq_q, eq_d;
    logic gt_q, gt_d;
    logic lt_q, lt_d;

    // Results hold while in_valid is low so downstream ORs of y never glitch.
    always_comb begin
        vld_d = in_valid;
        eq_d  = eq_q;
        gt_d  = gt_q;
        lt_d  = lt_q;
        if (in_valid) begin
            eq_d = (a == b);
            gt_d = (a > b);
            lt_d = (a < b);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            eq_q  <= eq_d;
            gt_q  <= gt_d;
            lt_q  <= lt_d;
        end
    end

    assign out_valid = vld_q;
    assign y         = eq_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;

`ifdef STICKY_OR_EN
    logic sticky_q, sticky_d;

    // Clear wins over a match arriving in the same cycle.
    always_comb begin
        sticky_d = sticky_q | (in_valid & (a == b));
        if (sticky_clr) sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) sticky_q <= 1'b0;
        else      sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`endif

    property p_operands_known;
        @(posedge clk) disable iff (!rst) in_valid |-> !$isunknown({a, b});
    endproperty
    a_operands_known: assert property (p_operands_known);

endmodule

// File: tb/tb_two_bit_comparator.sv
// Scoreboard bench for two_bit_comparator: expected results queued at drive, popped at output.
module tb_two_bit_comparator;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] a = '0;
    logic [1:0] b = '0;
    logic       out_valid, y, eq, gt, lt;
`ifdef STICKY_OR_EN
    logic       sticky_clr = 1'b0;
    logic       sticky;
    logic       exp_stk = 1'b0;
`endif

    res_t sb[$];
    res_t held = '0;
    logic exp_vld = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    two_bit_comparator #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef STICKY_OR_EN
        .sticky_clr(sticky_clr),
        .sticky    (sticky),
`endif
        .out_valid (out_valid),
        .y         (y),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle, update the model, clock, then compare the post-edge outputs.
    task automatic cycle(input logic r, input logic v, input logic [1:0] av, input logic [1:0] bv);
        res_t r_new;
        rst = r; in_valid = v; a = av; b = bv;
        if (!r) begin
            sb.delete();
            exp_vld = 1'b0;
            held    = '0;
        end else begin
            if (v) begin
                r_new.eq = (av == bv);
                r_new.gt = (av > bv);
                r_new.lt = (av < bv);
                sb.push_back(r_new);
            end
            exp_vld = v;
        end
`ifdef STICKY_OR_EN
        if (!r || sticky_clr) exp_stk = 1'b0;
        else                  exp_stk = exp_stk | (v && (av == bv));
`endif
        @(posedge clk);
        #1;
        if (exp_vld) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else                held = sb.pop_front();
        end
        chk("out_valid", out_valid, exp_vld);
        chk("y", y, held.eq);
        chk("eq", eq, held.eq);
        chk("gt", gt, held.gt);
        chk("lt", lt, held.lt);
        if (exp_vld) chk("onehot", $countones({eq, gt, lt}), 32'd1);
`ifdef STICKY_OR_EN
        chk("sticky", sticky, exp_stk);
`endif
    endtask

    initial begin
        // reset with a live matching sample must not leak through
        cycle(1'b0, 1'b1, 2'd3, 2'd3);
        cycle(1'b0, 1'b1, 2'd3, 2'd3);
        // first match after release
        cycle(1'b1, 1'b1, 2'd2, 2'd2);
        // back-to-back gt then lt
        cycle(1'b1, 1'b1, 2'd3, 2'd1);
        cycle(1'b1, 1'b1, 2'd0, 2'd2);
        // hold after a gt result while an idle match sits on the inputs
        cycle(1'b1, 1'b1, 2'd3, 2'd1);
        cycle(1'b1, 1'b0, 2'd1, 2'd1);
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        // exhaustive sweep, back-to-back
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                cycle(1'b1, 1'b1, 2'(i), 2'(j));
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
`ifdef STICKY_OR_EN
        sticky_clr = 1'b1;
        cycle(1'b1, 1'b0, 2'd0, 2'd0);
        sticky_clr = 1'b0;
        cycle(1'b1, 1'b1, 2'd0, 2'd1);
        cycle(1'b1, 1'b1, 2'd2, 2'd2);
        cycle(1'b1, 1'b1, 2'd0, 2'd3);
        cycle(1'b1, 1'b0, 2'd1, 2'd1);
        sticky_clr = 1'b1;
        cycle(1'b1, 1'b1, 2'd1, 2'd1);
        sticky_clr = 1'b0;
        cycle(1'b1, 1'b1, 2'd0, 2'd2);
`endif
        // random traffic with a mid-stream reset
        for (int k = 0; k < 60; k++) begin
`ifdef STICKY_OR_EN
            sticky_clr = ($urandom_range(0, 7) == 0);
`endif
            cycle((k != 30), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        chk("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
